serial_bit_streamer: RTL and testbench
======================================

Name: serial_bit_streamer

Overview:
- Parallel-in, serial-out stage directly upstream of the 1100 Mealy sequence detector; produces the detector's serial `x` input.
- Accepts WIDTH-bit words over a valid/ready handshake and double-buffers them (holding register + shift register).
- Shifts one bit per enabled clock with no gap between consecutive words.
- Marks bit validity and word completion so test/DUT wrappers can align detector output `z` with the bit stream.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted out first; 0 = bit 0 first.
- IDLE_BIT, 0, value driven on `x` when no word is shifting.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data valid.
- in_ready  output  1  holding register empty; word accepted on edge where in_valid && in_ready.
- en  input  1  bit-advance enable; 0 stalls the stream.
- x  output  1  current serial bit (registered); connects to detector x.
- x_valid  output  1  x carries a real data bit.
- word_done  output  1  one-cycle pulse, last bit of a word consumed.
- busy  output  1  x_valid || hold_full.

Behaviour:
- Reset (async, any time incl. mid-word):
  - hold_full=0, shifter empty, bit_cnt=0.
  - in_ready=1, x=IDLE_BIT, x_valid=0, word_done=0, busy=0.
  - In-flight and held words are discarded.
- Storage:
  - hold_reg/hold_full: one-word buffer.
  - shift_reg: active word.
  - bit_cnt: width $clog2(WIDTH), counts bits already consumed.
- in_ready = !hold_full (registered, no combinational path from en or in_valid).
- Accept: on edge with in_valid && in_ready -> hold_reg <= in_data, hold_full <= 1. in_data is ignored when in_ready=0.
- State machine:
  - IDLE: x_valid=0, x=IDLE_BIT. If hold_full at an edge -> load shift_reg from hold_reg, clear hold_full, bit_cnt=0, go to SHIFT. en is not required to load.
  - SHIFT: x = first/next bit per MSB_FIRST; x_valid=1.
    - Edge with en=1: bit consumed, bit_cnt+1, shift toward the output bit.
    - Edge with en=0: x, x_valid, bit_cnt all hold.
  - Last bit (bit_cnt==WIDTH-1) consumed with en=1:
    - word_done pulses high for the next cycle.
    - If hold_full: load the next word on the same edge, stay in SHIFT (zero-gap, continuous stream).
    - Else: go to IDLE; x=IDLE_BIT, x_valid=0 from that edge.
- Latency: word accepted at edge N, empty pipeline -> first bit valid on x after edge N+1. A word spans exactly WIDTH enabled cycles.
- Simultaneous events:
  - Accept and transfer on the same edge cannot collide, because accept requires hold_full=0.
  - A transfer on edge E makes in_ready=1 from E, so a new word can be accepted at E+1.
  - Sustained en=1 with in_valid=1 gives 100% bit throughput.
- x updates only on clock edges; it never glitches relative to in_data.
- word_done is never asserted while en=0 except as the single cycle after the completing edge.

Test Plan:
- Reset, then push 8'hCC (MSB_FIRST=1), en=1 -> x = 1,1,0,0,1,1,0,0 on 8 consecutive cycles starting one cycle after accept; x_valid high 8 cycles; word_done one pulse after the 8th bit; connected detector z pulses twice (non-overlapping 1100).
- Back-to-back 8'hF0, 8'h0F with in_valid held high -> 16 contiguous valid bits 11110000 00001111, no x_valid gap; in_ready low while holding register is occupied.
- MSB_FIRST=0, word 8'h01 -> x sequence 1,0,0,0,0,0,0,0.
- Stall: 8'hA5 with en=0 for 3 cycles after the 3rd bit -> x holds bit value 1 (bit 5), bit_cnt frozen; resume yields the remaining 0,0,1,0,1 exactly once.
- Reset asserted asynchronously mid-word (after 4 bits) with a word held -> x=IDLE_BIT, x_valid=0, in_ready=1 immediately; no residual bits after release.
- Idle: no input for 10 cycles -> x=IDLE_BIT, x_valid=0, busy=0, word_done never asserted.

Source files
------------

// File: rtl/serial_bit_streamer.sv
// serial_bit_streamer: parallel-in, serial-out feeder for the 1100 sequence detector.
// Words arrive over valid/ready into a one-word holding register and are shifted
// out one bit per enabled clock from a shift register, with no gap between words.
module serial_bit_streamer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hold_reg_q, hold_reg_d;
  logic               hold_full_q, hold_full_d;
  logic [WIDTH-1:0]   shift_reg_q, shift_reg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               x_d, x_valid_d, word_done_d, busy_d, in_ready_d;

  // Bit presented on x for a given shift register content.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Move the next bit into the output position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d     = state_q;
    hold_reg_d  = hold_reg_q;
    hold_full_d = hold_full_q;
    shift_reg_d = shift_reg_q;
    bit_cnt_d   = bit_cnt_q;
    word_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shift_reg_d = hold_reg_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          if (bit_cnt_q == LAST_CNT) begin
            word_done_d = 1'b1;
            bit_cnt_d   = '0;
            if (hold_full_q) begin
              shift_reg_d = hold_reg_q;
              hold_full_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d   = bit_cnt_q + CNT_W'(1);
            shift_reg_d = advance(shift_reg_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept cannot coincide with a transfer: it needs the holding register empty.
    if (in_valid && !hold_full_q) begin
      hold_reg_d  = in_data;
      hold_full_d = 1'b1;
    end

    x_valid_d  = (state_d == SHIFT);
    x_d        = x_valid_d ? out_bit(shift_reg_d) : IDLE_BIT;
    busy_d     = x_valid_d || hold_full_d;
    in_ready_d = !hold_full_d;
  end

  // State and output registers; asynchronous reset discards all words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_reg_q  <= '0;
      hold_full_q <= 1'b0;
      shift_reg_q <= '0;
      bit_cnt_q   <= '0;
      x           <= IDLE_BIT;
      x_valid     <= 1'b0;
      word_done   <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_reg_q  <= hold_reg_d;
      hold_full_q <= hold_full_d;
      shift_reg_q <= shift_reg_d;
      bit_cnt_q   <= bit_cnt_d;
      x           <= x_d;
      x_valid     <= x_valid_d;
      word_done   <= word_done_d;
      busy        <= busy_d;
      in_ready    <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_serial_bit_streamer.sv
// Bench for serial_bit_streamer: an MSB-first and an LSB-first instance share stimulus
// and are checked every cycle against a word-queue reference model.
module tb_serial_bit_streamer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         en;
  logic         in_ready_a, x_a, x_valid_a, word_done_a, busy_a;
  logic         in_ready_b, x_b, x_valid_b, word_done_b, busy_b;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: active word plus index of bits consumed, and one held word.
  bit           m_act;
  logic [W-1:0] m_word;
  int           m_idx;
  bit           m_held_v;
  logic [W-1:0] m_held;
  bit           m_done;

  serial_bit_streamer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .en(en), .x(x_a), .x_valid(x_valid_a), .word_done(word_done_a), .busy(busy_a)
  );

  serial_bit_streamer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .en(en), .x(x_b), .x_valid(x_valid_b), .word_done(word_done_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_act = 0; m_idx = 0; m_held_v = 0; m_done = 0; m_word = '0; m_held = '0;
  endtask

  task automatic check_all();
    chk("x_a",         32'(x_a),         32'(m_act ? m_word[W-1-m_idx] : 1'b0));
    chk("x_b",         32'(x_b),         32'(m_act ? m_word[m_idx] : 1'b1));
    chk("x_valid_a",   32'(x_valid_a),   32'(m_act));
    chk("x_valid_b",   32'(x_valid_b),   32'(m_act));
    chk("in_ready_a",  32'(in_ready_a),  32'(!m_held_v));
    chk("in_ready_b",  32'(in_ready_b),  32'(!m_held_v));
    chk("busy_a",      32'(busy_a),      32'(m_act || m_held_v));
    chk("word_done_a", 32'(word_done_a), 32'(m_done));
    chk("word_done_b", 32'(word_done_b), 32'(m_done));
  endtask

  // One clock: advance the model with the inputs present at the edge, then check.
  task automatic step();
    bit held_before;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      held_before = m_held_v;
      m_done = 0;
      if (m_act && en) begin
        m_idx++;
        if (m_idx == W) begin
          m_done = 1;
          m_act  = 0;
        end
      end
      if (!m_act && held_before) begin
        m_act = 1; m_word = m_held; m_idx = 0; m_held_v = 0;
      end
      if (in_valid && !held_before) begin
        m_held = in_data; m_held_v = 1;
      end
    end
    #1;
    check_all();
  endtask

  // Present a word until it is accepted; in_valid is left high for the caller.
  task automatic push(input logic [W-1:0] w);
    bit acc = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 50 && !acc; t++) begin
      acc = in_ready_a;
      step();
    end
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  // Send one word with en=1 and gather its bits from both instances.
  task automatic send_collect(input logic [W-1:0] w, output logic [W-1:0] ba,
                              output logic [W-1:0] bb);
    en = 1'b1;
    push(w);
    in_valid = 1'b0;
    ba = '0; bb = '0;
    for (int i = 0; i < W; i++) begin
      step();
      ba = {ba[W-2:0], x_a};
      bb = {x_b, bb[W-1:1]};
    end
  endtask

  initial begin
    logic [W-1:0] ba, bb;
    logic [4:0]   tail;
    rst = 1'b1; in_valid = 1'b0; en = 1'b0; in_data = '0;
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();

    // Single word 8'hCC, MSB-first pattern 11001100, one word_done pulse after.
    send_collect(8'hCC, ba, bb);
    chk("cc_seq_msb", 32'(ba), 32'h00CC);
    chk("cc_seq_lsb", 32'(bb), 32'h00CC);
    step();
    chk("cc_done", 32'(word_done_a), 32'd1);
    step();
    chk("cc_idle_x", 32'(x_a), 32'd0);

    // LSB-first instance sees 8'h01 as 1 then seven zeros.
    send_collect(8'h01, ba, bb);
    chk("w01_lsb", 32'(bb), 32'h0001);
    chk("w01_msb", 32'(ba), 32'h0001);
    repeat (2) step();

    // Back-to-back words with in_valid held: contiguous 16-bit stream.
    en = 1'b1;
    push(8'hF0);
    push(8'h0F);
    in_valid = 1'b0;
    chk("b2b_hold_full", 32'(in_ready_a), 32'd0);
    repeat (18) step();

    // Stall on the third bit of 8'hA5 for three cycles, then finish the word.
    push(8'hA5);
    in_valid = 1'b0;
    repeat (3) step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_x", 32'(x_a), 32'd1);
      chk("stall_vld", 32'(x_valid_a), 32'd1);
    end
    en = 1'b1;
    tail = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      tail = {tail[3:0], x_a};
    end
    chk("stall_tail", 32'(tail), 32'h05);
    repeat (2) step();

    // Asynchronous reset mid-word with a second word held.
    push(8'h3C);
    push(8'h99);
    in_valid = 1'b0;
    repeat (3) step();
    chk("pre_rst_held", 32'(in_ready_a), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_x_a", 32'(x_a), 32'd0);
    chk("arst_x_b", 32'(x_b), 32'd1);
    chk("arst_vld", 32'(x_valid_a), 32'd0);
    chk("arst_rdy", 32'(in_ready_a), 32'd1);
    chk("arst_busy", 32'(busy_a), 32'd0);
    step();
    rst = 1'b0;
    repeat (12) step();

    // Idle with random en: nothing moves.
    for (int i = 0; i < 10; i++) begin
      en = 1'($urandom_range(0, 1));
      step();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      step();
    end
    in_valid = 1'b0;
    en = 1'b1;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
